cr_xp10_comp_be_data_packer: RTL and testbench

CR_XP10_COMP_BE_DATA_PACKER -- requirements
Module: cr_xp10_comp_be_data_packer

---
 rtl/cr_xp10_compPKG.sv | 21 ++
 rtl/nx_fifo.sv | 62 ++++++
 rtl/cr_xp10_comp_be_data_packer.sv | 153 +++++++++++++++
 tb/tb_cr_xp10_comp_be_data_packer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cr_xp10_compPKG.sv
// Shared types for the XP10 compression back-end data path.
package cr_xp10_compPKG;

    localparam int AXI_S_DP_DWIDTH = 64;

    // One output word of the back-end packer; bytes_valid 0 means all 8 bytes.
    typedef struct packed {
        logic [AXI_S_DP_DWIDTH-1:0] data;
        logic                       sof;
        logic                       eof;
        logic [2:0]                 bytes_valid;
    } be_dp_bus_t;

    // Byte count of a residual of n bits (1..63), wrapped mod 8.
    function automatic logic [2:0] bytes_of_bits(input logic [6:0] n);
        logic [7:0] t;
        t = {1'b0, n} + 8'd7;
        return t[5:3];
    endfunction

endpackage

// File: rtl/nx_fifo.sv
// Synchronous FIFO with flush, occupancy count and zeroed read data when empty.
module nx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             rd,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    used
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign empty = (used == '0);
    assign full  = (used == CW'(DEPTH));
    assign do_rd = rd && !empty;
    // A write into a full FIFO is still accepted when the head leaves this cycle.
    assign do_wr = wr && (!full || do_rd);
    assign rdata = empty ? '0 : mem[rd_ptr];

    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Pointer and occupancy bookkeeping; clr empties the FIFO.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_wr) wr_ptr <= bump(wr_ptr);
            if (do_rd) rd_ptr <= bump(rd_ptr);
            case ({do_wr, do_rd})
                2'b10:   used <= used + 1'b1;
                2'b01:   used <= used - 1'b1;
                default: ;
            endcase
        end
    end

    // Storage array, no reset needed since reads of empty slots are masked.
    always_ff @(posedge clk) begin
        if (do_wr && !clr) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/cr_xp10_comp_be_data_packer.sv
// Packs variable-length bit fields LSB-first into 64-bit words queued in a FIFO.
module cr_xp10_comp_be_data_packer
    import cr_xp10_compPKG::*;
#(
    parameter int DEPTH    = 8,
    parameter int AFULL_TH = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] pack_wdata,
    input  logic [6:0]  pack_len,
    input  logic        pack_sof,
    input  logic        pack_eof,
    input  logic        pack_wr,
    input  logic        pack_clear,
    input  logic        pack_ack,
    output be_dp_bus_t  pack_rdata,
    output logic        pack_rd,
    output logic        pack_afull,
    output logic        pack_busy,
    output logic        pack_err
);

    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, FLUSH = 2'd2} state_t;

    state_t       state_q, state_d;
    logic [127:0] acc_q, acc_d, merged;
    logic [6:0]   fill_q, fill_d;
    logic [7:0]   sum;
    logic [63:0]  field_mask;
    logic         sof_pend_q, sof_pend_d, sof_now;
    logic         len_ok, accept, bad_wr;
    logic         word_vld, stg_vld;
    be_dp_bus_t   word_d, stg_q;
    logic         pop, ovfl, fifo_empty, fifo_full;
    logic [CW-1:0] fifo_used;
    logic [$bits(be_dp_bus_t)-1:0] fifo_rdata;

    assign pack_busy = (state_q == FLUSH);
    assign len_ok    = (pack_len != 7'd0) && (pack_len <= 7'd64);
    assign accept    = pack_wr && len_ok && !pack_busy;
    assign bad_wr    = pack_wr && !accept;
    assign sof_now   = sof_pend_q | pack_sof;

    // Merge the accepted field into the accumulator and produce at most one word.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        fill_d     = fill_q;
        sof_pend_d = sof_pend_q;
        word_vld   = 1'b0;
        word_d     = '0;
        field_mask = (pack_len >= 7'd64) ? '1 : ((64'd1 << pack_len) - 64'd1);
        merged     = acc_q | ({64'd0, pack_wdata & field_mask} << fill_q);
        sum        = {1'b0, fill_q} + {1'b0, pack_len};
        if (state_q == FLUSH) begin
            // Residual word of an eof that spilled past one word.
            word_vld           = 1'b1;
            word_d.data        = acc_q[63:0];
            word_d.sof         = sof_pend_q;
            word_d.eof         = 1'b1;
            word_d.bytes_valid = bytes_of_bits(fill_q);
            sof_pend_d         = 1'b0;
            acc_d              = '0;
            fill_d             = '0;
            state_d            = IDLE;
        end else if (accept) begin
            sof_pend_d = sof_now;
            state_d    = ACTIVE;
            if (sum >= 8'd64) begin
                word_vld    = 1'b1;
                word_d.data = merged[63:0];
                word_d.sof  = sof_now;
                word_d.eof  = pack_eof && (sum == 8'd64);
                sof_pend_d  = 1'b0;
                acc_d       = merged >> 64;
                fill_d      = 7'(sum - 8'd64);
                if (pack_eof) state_d = (sum == 8'd64) ? IDLE : FLUSH;
            end else begin
                acc_d  = merged;
                fill_d = sum[6:0];
                if (pack_eof) begin
                    word_vld           = 1'b1;
                    word_d.data        = merged[63:0];
                    word_d.sof         = sof_now;
                    word_d.eof         = 1'b1;
                    word_d.bytes_valid = bytes_of_bits(sum[6:0]);
                    sof_pend_d         = 1'b0;
                    acc_d              = '0;
                    fill_d             = '0;
                    state_d            = IDLE;
                end
            end
        end
    end

    // Packer state, one-word staging register and sticky error; clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            fill_q     <= '0;
            sof_pend_q <= 1'b0;
            stg_vld    <= 1'b0;
            stg_q      <= '0;
            pack_err   <= 1'b0;
        end else if (pack_clear) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            fill_q     <= '0;
            sof_pend_q <= 1'b0;
            stg_vld    <= 1'b0;
            stg_q      <= '0;
            pack_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            fill_q     <= fill_d;
            sof_pend_q <= sof_pend_d;
            stg_vld    <= word_vld;
            stg_q      <= word_d;
            if (bad_wr || ovfl) pack_err <= 1'b1;
        end
    end

    assign pop  = pack_ack && !fifo_empty;
    // Staged word hitting a full FIFO with no pop is dropped and flagged.
    assign ovfl = stg_vld && fifo_full && !pop;

    nx_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(be_dp_bus_t)),
        .CW    (CW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (pack_clear),
        .wr    (stg_vld),
        .wdata (stg_q),
        .rd    (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .used  (fifo_used)
    );

    assign pack_rdata = be_dp_bus_t'(fifo_rdata);
    assign pack_rd    = !fifo_empty;
    assign pack_afull = 32'(fifo_used) > AFULL_TH;

endmodule

// File: tb/tb_cr_xp10_comp_be_data_packer.sv
// Scoreboard bench for the back-end data packer.
module tb_cr_xp10_comp_be_data_packer;
    import cr_xp10_compPKG::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [63:0] pack_wdata = '0;
    logic [6:0]  pack_len = '0;
    logic        pack_sof = 1'b0, pack_eof = 1'b0, pack_wr = 1'b0;
    logic        pack_clear = 1'b0, pack_ack = 1'b0;
    be_dp_bus_t  pack_rdata;
    logic        pack_rd, pack_afull, pack_busy, pack_err;

    int total = 0;
    int bad = 0;
    be_dp_bus_t exp_q[$];
    bit mbits[$];
    bit msof = 1'b0;

    cr_xp10_comp_be_data_packer #(.DEPTH(8), .AFULL_TH(5)) dut (
        .clk(clk), .rst_n(rst_n), .pack_wdata(pack_wdata), .pack_len(pack_len),
        .pack_sof(pack_sof), .pack_eof(pack_eof), .pack_wr(pack_wr),
        .pack_clear(pack_clear), .pack_ack(pack_ack), .pack_rdata(pack_rdata),
        .pack_rd(pack_rd), .pack_afull(pack_afull), .pack_busy(pack_busy),
        .pack_err(pack_err)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    // Scoreboard: every popped word must match the oldest expected word.
    always @(negedge clk) begin
        if (rst_n && !pack_clear && pack_rd && pack_ack) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL word: got unexpected data=%h sof=%b eof=%b bv=%0d, required none",
                         pack_rdata.data, pack_rdata.sof, pack_rdata.eof, pack_rdata.bytes_valid);
            end else begin
                be_dp_bus_t e;
                e = exp_q.pop_front();
                if (pack_rdata !== e) begin
                    bad++;
                    $display("FAIL word: got data=%h sof=%b eof=%b bv=%0d, required data=%h sof=%b eof=%b bv=%0d",
                             pack_rdata.data, pack_rdata.sof, pack_rdata.eof, pack_rdata.bytes_valid,
                             e.data, e.sof, e.eof, e.bytes_valid);
                end
            end
        end
    end

    // Bit-list reference model of the packer output stream.
    task automatic model_field(input logic [63:0] d, input int l, input bit s, input bit e);
        be_dp_bus_t w;
        int n;
        if (s) msof = 1'b1;
        for (int i = 0; i < l; i++) mbits.push_back(d[i]);
        if (mbits.size() >= 64) begin
            w = '0;
            for (int i = 0; i < 64; i++) w.data[i] = mbits.pop_front();
            w.sof = msof;
            msof = 1'b0;
            w.eof = e && (mbits.size() == 0);
            exp_q.push_back(w);
        end
        if (e && mbits.size() > 0) begin
            n = mbits.size();
            w = '0;
            for (int i = 0; i < n; i++) w.data[i] = mbits.pop_front();
            w.sof = msof;
            msof = 1'b0;
            w.eof = 1'b1;
            w.bytes_valid = 3'(((n + 7) / 8) % 8);
            exp_q.push_back(w);
        end
    endtask

    task automatic model_clear();
        mbits.delete();
        msof = 1'b0;
        exp_q.delete();
    endtask

    task automatic send(input logic [63:0] d, input logic [6:0] l, input bit s, input bit e, input bit track);
        pack_wdata = d; pack_len = l; pack_sof = s; pack_eof = e; pack_wr = 1'b1;
        if (track) model_field(d, int'(l), s, e);
        @(posedge clk); #1;
        pack_wr = 1'b0; pack_sof = 1'b0; pack_eof = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_clear();
        pack_clear = 1'b1;
        @(posedge clk); #1;
        pack_clear = 1'b0;
        model_clear();
    endtask

    task automatic drain();
        int n;
        n = 0;
        pack_ack = 1'b1;
        idle(3);
        while ((exp_q.size() != 0 || pack_rd) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (exp_q.size() != 0 || pack_rd) begin
            bad++;
            $display("FAIL drain: got left=%0d rd=%b, required left=0 rd=0", exp_q.size(), pack_rd);
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(2);
        total += 5;
        if (pack_rd !== 1'b0)    begin bad++; $display("FAIL reset_rd: got %b, required 0", pack_rd); end
        if (pack_rdata !== '0)   begin bad++; $display("FAIL reset_rdata: got %h, required 0", pack_rdata); end
        if (pack_afull !== 1'b0) begin bad++; $display("FAIL reset_afull: got %b, required 0", pack_afull); end
        if (pack_busy !== 1'b0)  begin bad++; $display("FAIL reset_busy: got %b, required 0", pack_busy); end
        if (pack_err !== 1'b0)   begin bad++; $display("FAIL reset_err: got %b, required 0", pack_err); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_eight_bytes();
        pack_ack = 1'b1;
        exp_q.push_back('{data: 64'h0807060504030201, sof: 1'b1, eof: 1'b1, bytes_valid: 3'd0});
        for (int i = 1; i <= 8; i++)
            send(64'hFFFF_FFFF_FFFF_FF00 | 64'(i), 7'd8, i == 1, i == 8, 1'b0);
        drain();
    endtask

    task automatic test_latency();
        pack_ack = 1'b0;
        exp_q.push_back('{data: 64'h5, sof: 1'b1, eof: 1'b1, bytes_valid: 3'd1});
        send(64'hFFFF_FFFF_FFFF_FFFD, 7'd3, 1'b1, 1'b1, 1'b0);
        total++;
        if (pack_rd !== 1'b0) begin bad++; $display("FAIL lat_early: got rd=%b, required 0", pack_rd); end
        idle(1);
        total += 2;
        if (pack_rd !== 1'b1) begin bad++; $display("FAIL lat_rd: got rd=%b, required 1", pack_rd); end
        if (pack_rdata.data !== 64'h5) begin bad++; $display("FAIL lat_data: got %h, required 5", pack_rdata.data); end
        drain();
    endtask

    task automatic test_flush_busy();
        pack_ack = 1'b1;
        exp_q.push_back('{data: 64'h5ABC_DEF0_1234_5678, sof: 1'b1, eof: 1'b0, bytes_valid: 3'd0});
        exp_q.push_back('{data: 64'hD, sof: 1'b0, eof: 1'b1, bytes_valid: 3'd1});
        send(64'hFABC_DEF0_1234_5678, 7'd60, 1'b1, 1'b0, 1'b0);
        total++;
        if (pack_busy !== 1'b0) begin bad++; $display("FAIL busy_pre: got %b, required 0", pack_busy); end
        send(64'hFFFF_FFFF_FFFF_FFD5, 7'd8, 1'b0, 1'b1, 1'b0);
        total++;
        if (pack_busy !== 1'b1) begin bad++; $display("FAIL busy_flush: got %b, required 1", pack_busy); end
        send(64'h77, 7'd8, 1'b1, 1'b1, 1'b0);
        total += 2;
        if (pack_busy !== 1'b0) begin bad++; $display("FAIL busy_post: got %b, required 0", pack_busy); end
        if (pack_err !== 1'b1)  begin bad++; $display("FAIL err_busy_wr: got %b, required 1", pack_err); end
        drain();
        do_clear();
        total++;
        if (pack_err !== 1'b0) begin bad++; $display("FAIL err_clear: got %b, required 0", pack_err); end
    endtask

    task automatic test_bad_len();
        pack_ack = 1'b1;
        send(64'h1, 7'd0, 1'b1, 1'b1, 1'b0);
        total++;
        if (pack_err !== 1'b1) begin bad++; $display("FAIL err_len0: got %b, required 1", pack_err); end
        send(64'h1, 7'd65, 1'b1, 1'b1, 1'b0);
        drain();
        do_clear();
        send(64'h1, 7'd65, 1'b1, 1'b1, 1'b0);
        total++;
        if (pack_err !== 1'b1) begin bad++; $display("FAIL err_len65: got %b, required 1", pack_err); end
        drain();
        do_clear();
    endtask

    task automatic test_overflow();
        pack_ack = 1'b0;
        for (int i = 0; i < 18; i++) begin
            send({$urandom(), $urandom()}, 7'd64, i == 0, 1'b0, i < 8);
            total += 2;
            if (pack_afull !== (i >= 6)) begin
                bad++; $display("FAIL afull[%0d]: got %b, required %b", i, pack_afull, i >= 6);
            end
            if (pack_err !== (i >= 9)) begin
                bad++; $display("FAIL ovfl_err[%0d]: got %b, required %b", i, pack_err, i >= 9);
            end
        end
        idle(1);
        drain();
        do_clear();
        total++;
        if (pack_err !== 1'b0) begin bad++; $display("FAIL ovfl_clear: got %b, required 0", pack_err); end
    endtask

    task automatic test_clear();
        pack_ack = 1'b0;
        send({$urandom(), $urandom()}, 7'd64, 1'b1, 1'b0, 1'b1);
        send({$urandom(), $urandom()}, 7'd64, 1'b0, 1'b0, 1'b1);
        send({$urandom(), $urandom()}, 7'd64, 1'b0, 1'b0, 1'b1);
        send({$urandom(), $urandom()}, 7'd37, 1'b0, 1'b0, 1'b1);
        total++;
        if (pack_rd !== 1'b1) begin bad++; $display("FAIL clr_pre: got rd=%b, required 1", pack_rd); end
        do_clear();
        total++;
        if (pack_rd !== 1'b0) begin bad++; $display("FAIL clr_rd: got rd=%b, required 0", pack_rd); end
        idle(3);
        total++;
        if (pack_rd !== 1'b0) begin bad++; $display("FAIL clr_late: got rd=%b, required 0", pack_rd); end
        pack_ack = 1'b1;
        send(64'hABCD, 7'd16, 1'b1, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_reset_midframe();
        pack_ack = 1'b1;
        send(64'h3FF, 7'd20, 1'b1, 1'b0, 1'b0);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(3);
        total++;
        if (pack_rd !== 1'b0) begin bad++; $display("FAIL rst_mid: got rd=%b, required 0", pack_rd); end
        send(64'h5A, 7'd8, 1'b1, 1'b1, 1'b1);
        drain();
    endtask

    task automatic test_back_to_back();
        int nf, guard;
        logic [6:0] l;
        logic [63:0] d;
        bit last, need_flush;
        for (int f = 0; f < 8; f++) begin
            nf = $urandom_range(1, 12);
            for (int k = 0; k < nf; k++) begin
                l = 7'($urandom_range(1, 64));
                d = {$urandom(), $urandom()};
                last = (k == nf - 1);
                need_flush = last && (mbits.size() + int'(l) > 64);
                guard = 0;
                while (pack_afull && guard < 20) begin
                    pack_ack = 1'b1;
                    idle(1);
                    guard++;
                end
                pack_ack = 1'($urandom_range(0, 1));
                send(d, l, k == 0, last, 1'b1);
                if (need_flush) idle(1);
            end
        end
        drain();
    endtask

    initial begin
        test_reset();
        test_eight_bytes();
        test_latency();
        test_flush_busy();
        test_bad_len();
        test_overflow();
        test_clear();
        test_reset_midframe();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
